// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin arbiter and sequencer sharing one FPU among NUM_REQ requesters
// Purpose: accepts one request at a time, holds the FPU inputs stable, waits out
//   FPU_LAT edges, captures fpu_out and returns it tagged with the requester index.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (at most one ready bit high)
//   req_op/req_a/req_b     packed per-requester opcode and operands
//   rsp_valid/rsp_ready    response handshake; rsp_id, rsp_data carry the result
//   fpu_operation/a/b      registered drive into the FPU; fpu_out is its result
//   busy                   registered, high whenever the sequencer is not idle
module fpu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_data,
  output logic [1:0]            fpu_operation,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  input  logic [31:0]           fpu_out,
  output logic                  busy
);

  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan;
  logic           grant_found;
  logic           handshake;
  logic [CW-1:0]  wait_cnt;

  // Rotating priority search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (scan == IDW'(NUM_REQ - 1)) ? '0 : scan + IDW'(1);
      if (!grant_found && req_valid[scan]) begin
        grant_found = 1'b1;
        grant_idx   = scan;
      end
    end
  end

  // Ready is only offered while idle, so any valid+ready in IDLE is an accepted handshake.
  assign handshake = (state == S_IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (handshake) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  if (handshake) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last          <= IDW'(NUM_REQ - 1);
      rsp_id        <= '0;
      rsp_data      <= '0;
      fpu_operation <= '0;
      fpu_a         <= '0;
      fpu_b         <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
    end else begin
      // Registered from the next state so busy tracks (state != IDLE) exactly.
      busy <= (state_nxt != S_IDLE);
      if (handshake) begin
        fpu_operation <= req_op[2*grant_idx +: 2];
        fpu_a         <= req_a[32*grant_idx +: 32];
        fpu_b         <= req_b[32*grant_idx +: 32];
        rsp_id        <= grant_idx;
        last          <= grant_idx;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= CW'(FPU_LAT - 1);
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if ((state == S_WAIT) && (wait_cnt == '0)) begin
        rsp_data <= fpu_out;
      end
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - self-checking bench for fpu_share_arbiter
module tb_fpu_share_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with FPU_LAT=1
  logic [3:0]   req_valid, req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data, fpu_a, fpu_b, fpu_out;
  logic [1:0]   fpu_operation;
  logic         busy;

  // Instance with FPU_LAT=3
  logic [3:0]   r3_valid, r3_ready;
  logic [7:0]   r3_op;
  logic [127:0] r3_a, r3_b;
  logic         r3_rsp_valid, r3_rsp_ready;
  logic [1:0]   r3_rsp_id;
  logic [31:0]  r3_rsp_data, r3_fa, r3_fb, r3_fout;
  logic [1:0]   r3_fop;
  logic         r3_busy;

  fpu_share_arbiter #(.NUM_REQ(4), .FPU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
    .busy(busy)
  );

  fpu_share_arbiter #(.NUM_REQ(4), .FPU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_op(r3_op), .req_a(r3_a), .req_b(r3_b),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_id(r3_rsp_id), .rsp_data(r3_rsp_data),
    .fpu_operation(r3_fop), .fpu_a(r3_fa), .fpu_b(r3_fb), .fpu_out(r3_fout),
    .busy(r3_busy)
  );

  // Stand-in FPU: known IEEE results for the named vectors, NaN in gives all-ones,
  // otherwise an arbitrary but deterministic mix of the operands.
  function automatic logic [31:0] fpu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return 32'hFFFF_FFFF;
    if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'b10 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a + {b[15:0], b[31:16]}) ^ {30'd0, op};
  endfunction

  logic [31:0] f1_pipe;
  logic [31:0] f3_pipe [3];
  always @(posedge clk) begin
    if (rst) begin
      f1_pipe <= '0;
      f3_pipe[0] <= '0; f3_pipe[1] <= '0; f3_pipe[2] <= '0;
    end else begin
      f1_pipe <= fpu_f(fpu_operation, fpu_a, fpu_b);
      f3_pipe[0] <= fpu_f(r3_fop, r3_fa, r3_fb);
      f3_pipe[1] <= f3_pipe[0];
      f3_pipe[2] <= f3_pipe[1];
    end
  end
  assign fpu_out = f1_pipe;
  assign r3_fout = f3_pipe[2];

  // Per-requester jobs driving the LAT=1 instance
  logic [3:0]  vld;
  logic [1:0]  job_op [4];
  logic [31:0] job_a  [4];
  logic [31:0] job_b  [4];
  always_comb begin
    req_valid = vld;
    req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2]  = job_op[i];
      req_a[32*i +: 32] = job_a[i];
      req_b[32*i +: 32] = job_b[i];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    r3_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_contention_jobs();
    job_op[0] = 2'b10; job_a[0] = 32'h4000_0000; job_b[0] = 32'h4040_0000;
    job_op[1] = 2'b00; job_a[1] = 32'h3F80_0000; job_b[1] = 32'h4000_0000;
    job_op[2] = 2'b01; job_a[2] = 32'h40A0_0000; job_b[2] = 32'h3F80_0000;
    job_op[3] = 2'b11; job_a[3] = 32'h4120_0000; job_b[3] = 32'h4000_0000;
  endtask

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rdy;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  // Transaction-level reference for the random phase
  int          m_last, m_phase, m_cnt, m_id, gnt;
  logic [31:0] m_data;
  logic [3:0]  exp_r;

  initial begin
    tbl[0] = '{2, 2'b00, 32'h3F80_0000, 32'h4000_0000, 4'b0100, 32'h4040_0000};
    tbl[1] = '{0, 2'b10, 32'h4000_0000, 32'h4040_0000, 4'b0001, 32'h40C0_0000};
    tbl[2] = '{1, 2'b00, 32'h7FC0_0000, 32'h3F80_0000, 4'b0010, 32'hFFFF_FFFF};
    tbl[3] = '{3, 2'b01, 32'h3F80_0000, 32'h7F80_0001, 4'b1000, 32'hFFFF_FFFF};
    tbl[4] = '{3, 2'b11, 32'h1234_5678, 32'h0000_ABCD, 4'b1000, 32'hBE01_567B};
    tbl[5] = '{1, 2'b01, 32'h0000_0000, 32'h0000_0000, 4'b0010, 32'h0000_0001};

    for (int i = 0; i < 4; i++) begin
      job_op[i] = '0; job_a[i] = '0; job_b[i] = '0;
    end
    vld = '0; rsp_ready = 1'b1;
    r3_valid = '0; r3_op = '0; r3_a = '0; r3_b = '0; r3_rsp_ready = 1'b1;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fpu_op", fpu_operation, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst3_busy", r3_busy, 0);
    tick();

    // Table of single transactions, LAT=1
    for (int t = 0; t < 6; t++) begin
      job_op[tbl[t].id] = tbl[t].op;
      job_a[tbl[t].id]  = tbl[t].a;
      job_b[tbl[t].id]  = tbl[t].b;
      vld = tbl[t].rdy;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("tbl_ready", req_ready, tbl[t].rdy);
      chk("tbl_busy_c0", busy, 0);
      tick();
      vld = '0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        chk("tbl_busy", busy, 1);
        chk("tbl_rsp_valid", rsp_valid, (c == 3));
        chk("tbl_fpu_a", fpu_a, tbl[t].a);
        chk("tbl_fpu_b", fpu_b, tbl[t].b);
        if (c == 3) begin
          chk("tbl_rsp_id", rsp_id, tbl[t].id);
          chk("tbl_rsp_data", rsp_data, tbl[t].exp);
        end
        tick();
      end
      @(negedge clk);
      chk("tbl_busy_end", busy, 0);
      chk("tbl_rsp_valid_end", rsp_valid, 0);
      tick();
    end

    // Contention: all four valid, grant order 0,1,2,3,0 every 4 cycles
    do_reset();
    set_contention_jobs();
    vld = 4'hF;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_r = (c % 4 == 0 && c <= 16) ? 4'(1 << ((c / 4) % 4)) : 4'd0;
      chk("cont_ready", req_ready, exp_r);
      if (c % 4 == 3) begin
        chk("cont_rsp_valid", rsp_valid, 1);
        chk("cont_rsp_id", rsp_id, (c / 4) % 4);
        chk("cont_rsp_data", rsp_data,
            fpu_f(job_op[(c/4)%4], job_a[(c/4)%4], job_b[(c/4)%4]));
      end
      if (c == 3) chk("cont_mul", rsp_data, 32'h40C0_0000);
      tick();
    end

    // Backpressure: rsp_ready low for 5 RESP cycles
    do_reset();
    set_contention_jobs();
    vld = 4'hF;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rsp_ready = (c >= 8);
      @(negedge clk);
      if (c == 0) chk("bp_ready0", req_ready, 4'b0001);
      if (c >= 1 && c <= 2) chk("bp_no_rsp", rsp_valid, 0);
      if (c >= 3 && c <= 8) begin
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_id", rsp_id, 0);
        chk("bp_rsp_data", rsp_data, 32'h40C0_0000);
        chk("bp_ready_low", req_ready, 0);
      end
      if (c >= 1 && c <= 8) begin
        chk("bp_fpu_a", fpu_a, 32'h4000_0000);
        chk("bp_fpu_b", fpu_b, 32'h4040_0000);
      end
      if (c == 9) chk("bp_next_grant", req_ready, 4'b0010);
      tick();
    end

    // Reset in WAIT: request lost, pointer back to requester 0
    do_reset();
    set_contention_jobs();
    vld = 4'b0001;
    @(negedge clk);
    chk("rw_ready0", req_ready, 4'b0001);
    tick();
    vld = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_busy", busy, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_fpu_op", fpu_operation, 0);
    chk("rw_fpu_a", fpu_a, 0);
    chk("rw_fpu_b", fpu_b, 0);
    chk("rw_rsp_id", rsp_id, 0);
    chk("rw_rsp_data", rsp_data, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rw_no_rsp", rsp_valid, 0);
      tick();
    end
    vld = 4'b0011;
    @(negedge clk);
    chk("rw_regrant", req_ready, 4'b0001);
    tick();
    vld = '0;
    for (int c = 0; c < 4; c++) tick();

    // Dropped request while busy does not move the pointer
    do_reset();
    set_contention_jobs();
    rsp_ready = 1'b1;
    vld = 4'b0001;
    @(negedge clk);
    chk("drop_ready0", req_ready, 4'b0001);
    tick();
    vld = 4'b0010;
    @(negedge clk);
    chk("drop_busy_ready", req_ready, 0);
    tick();
    vld = '0;
    tick();
    @(negedge clk);
    chk("drop_rsp_id", rsp_id, 0);
    tick();
    vld = 4'b0011;
    @(negedge clk);
    chk("drop_next_grant", req_ready, 4'b0010);
    tick();
    vld = '0;
    for (int c = 0; c < 4; c++) tick();

    // FPU_LAT=3 with NaN operand
    do_reset();
    r3_op = 8'b0000_0000;
    r3_a  = '0; r3_a[63:32] = 32'h7FC0_0000;
    r3_b  = '0; r3_b[63:32] = 32'h3F80_0000;
    r3_valid = 4'b0010;
    r3_rsp_ready = 1'b1;
    @(negedge clk);
    chk("lat3_ready", r3_ready, 4'b0010);
    tick();
    r3_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("lat3_rsp_valid", r3_rsp_valid, (c == 5));
      chk("lat3_busy", r3_busy, (c <= 5));
      if (c == 5) begin
        chk("lat3_rsp_id", r3_rsp_id, 1);
        chk("lat3_rsp_data", r3_rsp_data, 32'hFFFF_FFFF);
      end
      tick();
    end

    // Randomized traffic against the transaction-level reference
    do_reset();
    m_last = 3; m_phase = 0; m_cnt = 0; m_id = 0; m_data = '0;
    for (int i = 0; i < 4; i++) begin
      job_op[i] = 2'($urandom); job_a[i] = $urandom; job_b[i] = $urandom;
    end
    vld = 4'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      rsp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      gnt = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (gnt < 0 && vld[(m_last + k) % 4]) gnt = (m_last + k) % 4;
        end
      end
      exp_r = (gnt >= 0) ? 4'(1 << gnt) : 4'd0;
      chk("rnd_ready", req_ready, exp_r);
      chk("rnd_rsp_valid", rsp_valid, (m_phase == 2));
      chk("rnd_busy", busy, (m_phase != 0));
      if (m_phase == 2) begin
        chk("rnd_rsp_id", rsp_id, m_id);
        chk("rnd_rsp_data", rsp_data, m_data);
      end
      if (gnt >= 0) begin
        m_last = gnt; m_id = gnt; m_phase = 1; m_cnt = 2;
        m_data = fpu_f(job_op[gnt], job_a[gnt], job_b[gnt]);
      end else if (m_phase == 1) begin
        m_cnt--;
        if (m_cnt == 0) m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
        m_phase = 0;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (i == gnt) begin
          job_op[i] = 2'($urandom); job_a[i] = $urandom; job_b[i] = $urandom;
          vld[i] = 1'($urandom);
        end else if (vld[i]) begin
          if ($urandom % 16 == 0) vld[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          job_op[i] = 2'($urandom); job_a[i] = $urandom; job_b[i] = $urandom;
          vld[i] = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
